conv_x_stream_driver: RTL and testbench
=======================================

# conv_x_stream_driver

Host-side counterpart of the 1-D convolution core (N=16, M=4, T=16, P=1). It buffers one X vector loaded by the host and transmits it as the valid/ready master that drives the core's X slave port. It then acts as the valid/ready slave that drains the core's Y output stream, forwarding each result to the host with an index. It sits between the test/host logic and the conv core and closes the loop for one vector per pass.

## Interface
- N, 16, X vector length in samples
- M, 4, filter length; Y count per vector is NY = N-M+1 = 13
- T, 16, sample width in bits (signed)

- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low; one clock; reset is asynchronous and active-low
- load_data  in  T  host X sample
- load_valid  in  1  host sample valid
- load_ready  out  1  driver accepts host sample
- m_data_out_x  out  T  X sample to conv core
- m_valid_x  out  1  X sample valid
- m_ready_x  in  1  conv core accepts X
- s_data_in_y  in  T  Y result from conv core
- s_valid_y  in  1  Y valid
- s_ready_y  out  1  driver accepts Y
- y_data  out  T  registered Y result to host
- y_valid  out  1  one-cycle strobe, y_data/y_idx valid
- y_idx  out  $clog2(NY)  index 0..NY-1 of y_data
- vec_done  out  1  one-cycle pulse after last Y of a vector

## Operation
- FSM states: LOAD, SEND, RECV, DONE. Reset state LOAD.
- LOAD: load_ready=1. Each load_valid&&load_ready writes load_data to xbuf[wcnt] and increments wcnt. On the transfer with wcnt==N-1: wcnt->0, go SEND.
- SEND: m_valid_x=1, m_data_out_x=xbuf[scnt]. Each m_valid_x&&m_ready_x increments scnt. On the transfer with scnt==N-1: scnt->0, go RECV.
- RECV: s_ready_y=1. Each s_valid_y&&s_ready_y registers s_data_in_y into y_data, asserts y_valid next cycle with y_idx=rcnt, and increments rcnt. On the transfer with rcnt==NY-1: rcnt->0, go DONE.
- DONE: vec_done=1 for exactly one cycle, then LOAD.
- Handshake outputs are pure decodes of state: load_ready, m_valid_x, and s_ready_y are each high only in their own state, so at most one is high at a time.
- Handshake rules:
  - m_valid_x stays high and m_data_out_x stays stable until accepted.
  - s_valid_y high while in any state other than RECV is simply not accepted; nothing is lost, the core holds the data.
- Counter wrap: each counter clears only on its terminal transfer; no modulo overflow past N-1 or NY-1.
- Arithmetic: no arithmetic on data; samples pass bit-exact and signed.
- The host has no backpressure on y_valid. The host must sink one result per cycle.

## Timing
- Reset values (async, while reset=0): state=LOAD, all counters 0, y_data=0, y_valid=0, y_idx=0, vec_done=0, m_valid_x=0, s_ready_y=0, load_ready=0.
  - load_ready rises in the first cycle after reset deasserts.
- xbuf contents are not reset.
- LOAD->SEND: m_valid_x is high in the cycle after the N-th host transfer.
- SEND->RECV: s_ready_y is high in the cycle after the N-th X transfer.
- Y latency: y_valid is asserted 1 cycle after the s_valid_y&&s_ready_y transfer.
- vec_done is in the cycle after the NY-th Y transfer, coincident with y_valid for idx NY-1. load_ready is high the cycle after that.
- Minimum pass with all peers always ready: N + N + NY + 1 = 46 cycles.
- Reset mid-operation (any state): immediate return to LOAD. Partial vectors and results are discarded. No y_valid or vec_done pulse is emitted.

## Structure
- Shared package conv_pkg:
  - state enum typedef (LOAD/SEND/RECV/DONE)
  - localparams N, M, T, NY
  - widths $clog2(N) and $clog2(NY)
- Natural sub-module: conv_xbuf, an N×T register array with one write port (wr_en, wr_addr, wr_data) and an async-read port. It has no reset.
- FSM, the three counters, and the Y output register live in the top.

## Test plan
- Reset/idle: hold reset=0 for 3 cycles with random inputs -> all outputs 0. Release -> load_ready=1 next cycle.
- Full pass, all ready:
  - Stimulus: load x[i]=i+1, i=0..15; m_ready_x=1; core returns y[j]=100+j for 13 Y.
  - Required: m_data_out_x sequence 1..16 on 16 consecutive cycles; y_data 100..112 with y_idx 0..12; vec_done one cycle after the last Y transfer; 46 cycles total.
- X backpressure: toggle m_ready_x randomly (50%) -> m_data_out_x stable while m_valid_x&&!m_ready_x; exactly 16 transfers, order 1..16.
- Early Y: assert s_valid_y with 0x7FFF during SEND -> s_ready_y=0, no y_valid. Value accepted as idx 0 once in RECV.
- Signed passthrough: x=-32768 and 32767, y=-1 -> bit-exact on m_data_out_x and y_data (0x8000, 0x7FFF, 0xFFFF).
- Reset mid-RECV: assert reset after 5 Y transfers -> immediate LOAD. Next full pass yields y_idx starting at 0 and 13 results.

Source files
------------

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared definitions for the conv core host-side stream driver.
//               Vector geometry, counter widths and the driver state type.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    localparam int N   = 16;          // X vector length in samples
    localparam int M   = 4;           // filter length
    localparam int T   = 16;          // sample width in bits (signed)
    localparam int NY  = N - M + 1;   // Y results per vector

    localparam int XAW = $clog2(N);
    localparam int YAW = $clog2(NY);

    // Terminal counter values; each counter clears only on its last transfer
    localparam logic [XAW-1:0] X_LAST = XAW'(N - 1);
    localparam logic [YAW-1:0] Y_LAST = YAW'(NY - 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SEND = 2'd1,
        RECV = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/conv_xbuf.sv
`default_nettype none
// ============================================================================
// Module      : conv_xbuf
// Description : N x T sample buffer holding one X vector.
//               One synchronous write port, one asynchronous read port.
//               Contents are not reset.
// Ports       : clk        - clock
//               wr_en_i    - write enable
//               wr_addr_i  - write address
//               wr_data_i  - write data
//               rd_addr_i  - read address
//               rd_data_o  - read data (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module conv_xbuf
    import conv_pkg::*;
(
    input  logic           clk,
    input  logic           wr_en_i,
    input  logic [XAW-1:0] wr_addr_i,
    input  logic [T-1:0]   wr_data_i,
    input  logic [XAW-1:0] rd_addr_i,
    output logic [T-1:0]   rd_data_o
);

    logic [T-1:0] mem_q [N];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule
`default_nettype wire

// File: rtl/conv_x_stream_driver.sv
`default_nettype none
// ============================================================================
// Module      : conv_x_stream_driver
// Description : Host-side driver for the 1-D convolution core. Buffers one X
//               vector from the host, streams it to the core as a valid/ready
//               master, then drains the core's Y stream as a valid/ready slave
//               and forwards each result to the host with its index.
// Ports       : clk, reset (async, active-low)
//               load_data/load_valid/load_ready       - host X input
//               m_data_out_x/m_valid_x/m_ready_x      - X stream to core
//               s_data_in_y/s_valid_y/s_ready_y       - Y stream from core
//               y_data/y_valid/y_idx                  - registered Y to host
//               vec_done                              - end-of-vector pulse
// Revision    : 1.0 - initial release
// ============================================================================
module conv_x_stream_driver
    import conv_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic [T-1:0]   load_data,
    input  logic           load_valid,
    output logic           load_ready,
    output logic [T-1:0]   m_data_out_x,
    output logic           m_valid_x,
    input  logic           m_ready_x,
    input  logic [T-1:0]   s_data_in_y,
    input  logic           s_valid_y,
    output logic           s_ready_y,
    output logic [T-1:0]   y_data,
    output logic           y_valid,
    output logic [YAW-1:0] y_idx,
    output logic           vec_done
);

    state_e         state_q, state_d;
    logic [XAW-1:0] wcnt_q, wcnt_d;
    logic [XAW-1:0] scnt_q, scnt_d;
    logic [YAW-1:0] rcnt_q, rcnt_d;
    logic           run_q;
    logic [T-1:0]   y_data_q, y_data_d;
    logic           y_valid_q, y_valid_d;
    logic [YAW-1:0] y_idx_q, y_idx_d;

    logic           load_fire;
    logic           x_fire;
    logic           y_fire;
    logic [T-1:0]   xbuf_rd;

    conv_xbuf u_xbuf (
        .clk       (clk),
        .wr_en_i   (load_fire),
        .wr_addr_i (wcnt_q),
        .wr_data_i (load_data),
        .rd_addr_i (scnt_q),
        .rd_data_o (xbuf_rd)
    );

    // run_q holds load_ready low while reset is asserted (state is already
    // LOAD then) and lets it rise on the first clock after release.
    assign load_ready = run_q && (state_q == LOAD);
    assign m_valid_x  = (state_q == SEND);
    assign s_ready_y  = (state_q == RECV);
    assign vec_done   = (state_q == DONE);

    assign load_fire  = load_valid && load_ready;
    assign x_fire     = m_valid_x && m_ready_x;
    assign y_fire     = s_valid_y && s_ready_y;

    // Buffer contents are unreset; only present them while actually sending.
    assign m_data_out_x = m_valid_x ? xbuf_rd : '0;

    assign y_data  = y_data_q;
    assign y_valid = y_valid_q;
    assign y_idx   = y_idx_q;

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        scnt_d    = scnt_q;
        rcnt_d    = rcnt_q;
        y_data_d  = y_data_q;
        y_idx_d   = y_idx_q;
        y_valid_d = 1'b0;

        case (state_q)
            LOAD: begin
                if (load_fire) begin
                    if (wcnt_q == X_LAST) begin
                        wcnt_d  = '0;
                        state_d = SEND;
                    end else begin
                        wcnt_d  = wcnt_q + 1'b1;
                    end
                end
            end
            SEND: begin
                if (x_fire) begin
                    if (scnt_q == X_LAST) begin
                        scnt_d  = '0;
                        state_d = RECV;
                    end else begin
                        scnt_d  = scnt_q + 1'b1;
                    end
                end
            end
            RECV: begin
                if (y_fire) begin
                    y_data_d  = s_data_in_y;
                    y_idx_d   = rcnt_q;
                    y_valid_d = 1'b1;
                    if (rcnt_q == Y_LAST) begin
                        rcnt_d  = '0;
                        state_d = DONE;
                    end else begin
                        rcnt_d  = rcnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = LOAD;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= LOAD;
            wcnt_q    <= '0;
            scnt_q    <= '0;
            rcnt_q    <= '0;
            run_q     <= 1'b0;
            y_data_q  <= '0;
            y_valid_q <= 1'b0;
            y_idx_q   <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            scnt_q    <= scnt_d;
            rcnt_q    <= rcnt_d;
            run_q     <= 1'b1;
            y_data_q  <= y_data_d;
            y_valid_q <= y_valid_d;
            y_idx_q   <= y_idx_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_x_stream_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_x_stream_driver
// Description : Directed self-checking bench for conv_x_stream_driver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_x_stream_driver;

    localparam int N  = 16;
    localparam int NY = 13;

    logic        clk;
    logic        reset;
    logic [15:0] load_data;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] m_data_out_x;
    logic        m_valid_x;
    logic        m_ready_x;
    logic [15:0] s_data_in_y;
    logic        s_valid_y;
    logic        s_ready_y;
    logic [15:0] y_data;
    logic        y_valid;
    logic [3:0]  y_idx;
    logic        vec_done;

    int errors = 0;
    int checks = 0;
    int cycles = 0;

    logic [15:0] xv [N];
    logic [15:0] yv [NY];

    conv_x_stream_driver dut (
        .clk          (clk),
        .reset        (reset),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .m_data_out_x (m_data_out_x),
        .m_valid_x    (m_valid_x),
        .m_ready_x    (m_ready_x),
        .s_data_in_y  (s_data_in_y),
        .s_valid_y    (s_valid_y),
        .s_ready_y    (s_ready_y),
        .y_data       (y_data),
        .y_valid      (y_valid),
        .y_idx        (y_idx),
        .vec_done     (vec_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cycles++;
    endtask

    // One vector pass starting in LOAD with load_ready already high.
    // rand_rdy : randomise m_ready_x during SEND
    // early    : present yv[0] on the Y port throughout SEND
    // abort_at : number of Y transfers before a mid-RECV reset (>= NY: none)
    task automatic run_pass(input bit rand_rdy, input bit early, input int abort_at);
        int j;
        int budget;
        int nrecv;
        bit rdy;
        cycles = 0;

        for (int i = 0; i < N; i++) begin
            load_valid = 1'b1;
            load_data  = xv[i];
            chk("load_ready", {31'd0, load_ready}, 32'd1);
            tick();
        end
        load_valid = 1'b0;
        load_data  = '0;
        chk("load_ready_off", {31'd0, load_ready}, 32'd0);

        if (early) begin
            s_valid_y   = 1'b1;
            s_data_in_y = yv[0];
        end

        j = 0;
        budget = 0;
        while (j < N && budget < 400) begin
            rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            m_ready_x = rdy;
            chk("m_valid_x", {31'd0, m_valid_x}, 32'd1);
            chk("m_data_out_x", {16'd0, m_data_out_x}, {16'd0, xv[j]});
            if (early) begin
                chk("early_s_ready", {31'd0, s_ready_y}, 32'd0);
                chk("early_y_valid", {31'd0, y_valid}, 32'd0);
            end
            tick();
            if (rdy) j++;
            budget++;
        end
        chk("send_count", j, N);
        m_ready_x = 1'b0;
        chk("m_valid_x_off", {31'd0, m_valid_x}, 32'd0);
        chk("s_ready_y_on", {31'd0, s_ready_y}, 32'd1);
        chk("y_valid_idle", {31'd0, y_valid}, 32'd0);

        nrecv = (abort_at < NY) ? abort_at : NY;
        for (int k = 0; k < nrecv; k++) begin
            s_valid_y   = 1'b1;
            s_data_in_y = yv[k];
            chk("s_ready_y", {31'd0, s_ready_y}, 32'd1);
            tick();
            chk("y_valid", {31'd0, y_valid}, 32'd1);
            chk("y_data", {16'd0, y_data}, {16'd0, yv[k]});
            chk("y_idx", {28'd0, y_idx}, k);
            chk("vec_done", {31'd0, vec_done}, (k == NY - 1) ? 32'd1 : 32'd0);
        end
        s_valid_y   = 1'b0;
        s_data_in_y = '0;

        if (abort_at < NY) begin
            reset = 1'b0;
            #1;
            chk("abort_y_valid", {31'd0, y_valid}, 32'd0);
            chk("abort_s_ready", {31'd0, s_ready_y}, 32'd0);
            chk("abort_y_idx", {28'd0, y_idx}, 32'd0);
            tick();
            chk("abort_vec_done", {31'd0, vec_done}, 32'd0);
            chk("abort_load_ready", {31'd0, load_ready}, 32'd0);
            tick();
            reset = 1'b1;
            tick();
            chk("abort_resume", {31'd0, load_ready}, 32'd1);
            chk("abort_no_pulse", {31'd0, vec_done | y_valid}, 32'd0);
        end else begin
            tick();
            chk("vec_done_off", {31'd0, vec_done}, 32'd0);
            chk("y_valid_off", {31'd0, y_valid}, 32'd0);
            chk("load_ready_back", {31'd0, load_ready}, 32'd1);
            if (!rand_rdy) chk("pass_cycles", cycles, 46);
        end
    endtask

    initial begin
        // Reset with random inputs
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            load_data   = 16'($urandom);
            load_valid  = 1'($urandom);
            m_ready_x   = 1'($urandom);
            s_data_in_y = 16'($urandom);
            s_valid_y   = 1'($urandom);
            tick();
            chk("rst_outs", {22'd0, load_ready, m_valid_x, s_ready_y, y_valid,
                             vec_done, y_idx, 1'b0}, 32'd0);
            chk("rst_y_data", {16'd0, y_data}, 32'd0);
            chk("rst_m_data", {16'd0, m_data_out_x}, 32'd0);
        end
        load_data = '0; load_valid = 1'b0; m_ready_x = 1'b0;
        s_data_in_y = '0; s_valid_y = 1'b0;
        reset = 1'b1;
        tick();
        chk("post_rst_load_ready", {31'd0, load_ready}, 32'd1);

        // Full pass, all ready
        for (int i = 0; i < N; i++) xv[i] = 16'(i + 1);
        for (int k = 0; k < NY; k++) yv[k] = 16'(100 + k);
        run_pass(1'b0, 1'b0, NY);

        // X backpressure with an early Y word waiting during SEND
        for (int i = 0; i < N; i++) xv[i] = 16'(i + 1);
        yv[0] = 16'h7FFF;
        run_pass(1'b1, 1'b1, NY);

        // Signed extremes
        xv[0] = 16'h8000;
        xv[1] = 16'h7FFF;
        yv[0] = 16'hFFFF;
        yv[1] = 16'h8000;
        run_pass(1'b0, 1'b0, NY);

        // Reset after 5 Y transfers, then a clean pass
        for (int i = 0; i < N; i++) xv[i] = 16'(16'h0100 + i);
        for (int k = 0; k < NY; k++) yv[k] = 16'(200 + k);
        run_pass(1'b0, 1'b0, 5);
        run_pass(1'b0, 1'b0, NY);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
